// File: rtl/ahb_bist_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bist_master
// Purpose  : AHB-Lite memory BIST master. Writes SEED^address over a region,
//            then reads it back and counts failing beats.
// Options  : BIST_INCR4_EN -- issue INCR4 bursts instead of SINGLE transfers.
// Revision : 1.0 -- initial release
// ============================================================================
module ahb_bist_master #(
  parameter logic [31:0] START_ADDR     = 32'h0,
  parameter int unsigned DEPTH_IN_BYTES = 2048,
  parameter logic [31:0] SEED           = 32'hA5A5_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic [1:0]  HRESP,
  input  logic        HREADY,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_cnt,
  output logic [31:0] err_addr
);

  localparam logic [1:0]  c_trans_idle   = 2'b00;
  localparam logic [1:0]  c_trans_nonseq = 2'b10;
  localparam logic [1:0]  c_trans_seq    = 2'b11;
  localparam logic [2:0]  c_size_word    = 3'b010;
  localparam logic [31:0] c_last_addr    = START_ADDR + 32'(DEPTH_IN_BYTES) - 32'd4;
`ifdef BIST_INCR4_EN
  localparam logic [2:0]  c_burst        = 3'b011;
`else
  localparam logic [2:0]  c_burst        = 3'b000;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_LAST = 3'd2,
    S_RD      = 3'd3,
    S_RD_LAST = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_dvalid;
  logic [31:0] r_daddr;

  logic [31:0] w_next_addr;
  logic [1:0]  w_next_trans;
  logic        w_start_acc;
  logic        w_beat_done;
  logic        w_fail;

  assign HSIZE       = c_size_word;
  assign w_next_addr = HADDR + 32'd4;
  assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef BIST_INCR4_EN
  // Beat position inside the 4-beat group, measured from START_ADDR.
  logic [1:0] w_next_beat;
  assign w_next_beat  = w_next_addr[3:2] - START_ADDR[3:2];
  assign w_next_trans = (w_next_beat == 2'b00) ? c_trans_nonseq : c_trans_seq;
`else
  assign w_next_trans = c_trans_nonseq;
`endif

  // A read data phase ends on any HREADY-high cycle while r_dvalid is set.
  assign w_beat_done = HREADY && r_dvalid;
  assign w_fail      = (HRDATA != (SEED ^ r_daddr)) || (HRESP != 2'b00);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      HADDR    <= START_ADDR;
      HTRANS   <= c_trans_idle;
      HWRITE   <= 1'b0;
      HBURST   <= 3'b000;
      HWDATA   <= 32'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r_dvalid <= 1'b0;
      r_daddr  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_WR;
            HADDR    <= START_ADDR;
            HTRANS   <= c_trans_nonseq;
            HWRITE   <= 1'b1;
            HBURST   <= c_burst;
            busy     <= 1'b1;
            done     <= 1'b0;
            r_dvalid <= 1'b0;
          end
        end
        S_WR: begin
          if (HREADY) begin
            HWDATA <= SEED ^ HADDR;
            if (HADDR == c_last_addr) begin
              r_state <= S_WR_LAST;
              HTRANS  <= c_trans_idle;
            end else begin
              HADDR  <= w_next_addr;
              HTRANS <= w_next_trans;
            end
          end
        end
        S_WR_LAST: begin
          if (HREADY) begin
            r_state <= S_RD;
            HADDR   <= START_ADDR;
            HTRANS  <= c_trans_nonseq;
            HWRITE  <= 1'b0;
          end
        end
        S_RD: begin
          if (HREADY) begin
            r_dvalid <= 1'b1;
            r_daddr  <= HADDR;
            if (HADDR == c_last_addr) begin
              r_state <= S_RD_LAST;
              HTRANS  <= c_trans_idle;
            end else begin
              HADDR  <= w_next_addr;
              HTRANS <= w_next_trans;
            end
          end
        end
        S_RD_LAST: begin
          if (HREADY) begin
            r_state  <= S_DONE;
            r_dvalid <= 1'b0;
            HBURST   <= 3'b000;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          HTRANS   <= c_trans_idle;
          r_dvalid <= 1'b0;
        end
      endcase
    end
  end

  // err_addr latches only the first failure of a pass.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cnt  <= 16'h0;
      err_addr <= 32'h0;
    end else if (w_start_acc) begin
      err_cnt  <= 16'h0;
      err_addr <= 32'h0;
    end else if (w_beat_done && w_fail) begin
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (err_cnt == 16'h0) begin
        err_addr <= r_daddr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_bist_master.sv
`default_nettype none
// Testbench for ahb_bist_master: randomized slave behaviour, reference
// transfer list and per-pass results checked by a scoreboard monitor.
module tb_ahb_bist_master;

  localparam logic [31:0] START = 32'h0;
  localparam int          DEPTH = 64;
  localparam int          N     = DEPTH / 4;
  localparam logic [31:0] SEED  = 32'hA5A5_0000;
`ifdef BIST_INCR4_EN
  localparam logic [2:0]  C_BURST = 3'b011;
  localparam bit          INCR4   = 1'b1;
`else
  localparam logic [2:0]  C_BURST = 3'b000;
  localparam bit          INCR4   = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        start = 1'b0;
  logic [31:0] HADDR, HWDATA, err_addr;
  logic [31:0] HRDATA = 32'h0;
  logic [1:0]  HTRANS;
  logic [1:0]  HRESP = 2'b00;
  logic        HWRITE, HREADY, busy, done;
  logic [2:0]  HSIZE, HBURST;
  logic [15:0] err_cnt;

  always #5 HCLK = ~HCLK;

  ahb_bist_master #(.START_ADDR(START), .DEPTH_IN_BYTES(DEPTH), .SEED(SEED)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP),
    .HREADY(HREADY), .busy(busy), .done(done),
    .err_cnt(err_cnt), .err_addr(err_addr)
  );

  typedef struct { logic [31:0] addr; logic wr; logic [1:0] trans; } xfer_t;
  typedef struct { int cnt; logic [31:0] addr; bit timed; } res_t;
  xfer_t exp_q[$];
  res_t  res_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Slave configuration and memory
  bit          rand_wait = 0;
  bit          resp_err = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_len = 0;
  bit          corrupt[N];
  logic [31:0] mem[N];

  function automatic int idx(logic [31:0] a);
    return int'(((a - START) >> 2) & (N - 1));
  endfunction

  // Slave: decides at each falling edge what the next rising edge will see.
  initial begin
    bit s_dp; bit s_wr; logic [31:0] s_addr; int s_wait;
    s_dp = 0; s_wr = 0; s_addr = 0; s_wait = 0;
    HREADY = 1'b1;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        s_dp = 0; s_wait = 0; HREADY = 1'b1; HRESP = 2'b00;
      end else if (s_dp && s_wait > 0) begin
        HREADY = 1'b0; HRESP = 2'b00; s_wait--;
      end else begin
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom;
        if (s_dp && s_wr) mem[idx(s_addr)] = HWDATA;
        if (s_dp && !s_wr) begin
          HRDATA = mem[idx(s_addr)] ^ (corrupt[idx(s_addr)] ? 32'h0000_0100 : 32'h0);
          HRESP  = resp_err ? 2'b01 : 2'b00;
        end
        s_dp = HTRANS[1];
        if (HTRANS[1]) begin
          s_addr = HADDR; s_wr = HWRITE;
          if (HWRITE && HADDR == stall_addr) s_wait = stall_len;
          else if (rand_wait && $urandom_range(0, 3) == 0) s_wait = $urandom_range(1, 2);
          else s_wait = 0;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit m_dp; bit m_wr; logic [31:0] m_addr;
    bit pbusy; bit pdone; int cyc; int t0;
    xfer_t e; res_t r;
    m_dp = 0; m_wr = 0; m_addr = 0; pbusy = 0; pdone = 0; cyc = 0; t0 = 0;
    forever begin
      @(negedge HCLK); #1;
      cyc++;
      if (!HRESETn) begin
        m_dp = 0; pbusy = 0; pdone = 0;
      end else begin
        if (busy && !pbusy) t0 = cyc;
        if (done && !pdone) begin
          if (res_q.size() == 0) chk("unexpected_done", {31'b0, done}, 32'h0);
          else begin
            r = res_q.pop_front();
            chk("err_cnt", {16'h0, err_cnt}, r.cnt);
            chk("err_addr", err_addr, r.addr);
            chk("busy_at_done", {31'b0, busy}, 32'h0);
            if (r.timed) chk("pass_cycles", cyc - t0, 2 * N + 2);
          end
        end
        pbusy = busy; pdone = done;
        if (HREADY) begin
          if (m_dp && m_wr) chk("hwdata", HWDATA, SEED ^ m_addr);
          m_dp = 0;
          if (HTRANS[1]) begin
            if (exp_q.size() == 0) chk("stray_transfer_htrans", {30'b0, HTRANS}, 32'h0);
            else begin
              e = exp_q.pop_front();
              chk("haddr", HADDR, e.addr);
              chk("hwrite", {31'b0, HWRITE}, {31'b0, e.wr});
              chk("htrans", {30'b0, HTRANS}, {30'b0, e.trans});
              chk("hburst", {29'b0, HBURST}, {29'b0, C_BURST});
              chk("hsize", {29'b0, HSIZE}, 32'h2);
              m_dp = 1; m_addr = HADDR; m_wr = HWRITE;
            end
          end
        end
      end
    end
  end

  // Reference model: ascending writes, then ascending reads, plus pass result.
  task automatic push_pass(bit timed);
    res_t r; int first;
    for (int w = 1; w >= 0; w--)
      for (int i = 0; i < N; i++)
        exp_q.push_back('{START + 4 * i, w[0],
                          (INCR4 && (i % 4 != 0)) ? 2'b11 : 2'b10});
    r.cnt = 0; first = -1;
    for (int i = 0; i < N; i++)
      if (resp_err || corrupt[i]) begin
        r.cnt++;
        if (first < 0) first = i;
      end
    r.addr  = (first < 0) ? 32'h0 : START + 4 * first;
    r.timed = timed;
    res_q.push_back(r);
  endtask

  task automatic pulse_start();
    @(negedge HCLK); #3 start = 1'b1;
    @(negedge HCLK); #3 start = 1'b0;
  endtask

  task automatic wait_done(bit stray);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge HCLK); #3;
      k++;
      if (stray && busy && k == 7) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", {31'b0, done}, 32'h1);
    repeat (2) @(negedge HCLK);
  endtask

  task automatic clear_cfg();
    rand_wait = 0; resp_err = 0; stall_addr = 32'hFFFF_FFFF; stall_len = 0;
    for (int i = 0; i < N; i++) corrupt[i] = 0;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_htrans"}, {30'b0, HTRANS}, 32'h0);
    chk({tag, "_haddr"}, HADDR, START);
    chk({tag, "_hwrite"}, {31'b0, HWRITE}, 32'h0);
    chk({tag, "_hsize"}, {29'b0, HSIZE}, 32'h2);
    chk({tag, "_hburst"}, {29'b0, HBURST}, 32'h0);
    chk({tag, "_hwdata"}, HWDATA, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_done"}, {31'b0, done}, 32'h0);
    chk({tag, "_err_cnt"}, {16'h0, err_cnt}, 32'h0);
    chk({tag, "_err_addr"}, err_addr, 32'h0);
  endtask

  initial begin
    int k;
    clear_cfg();
    #1 HRESETn = 1'b0;
    #2 check_reset_values("por");
    repeat (2) @(negedge HCLK);
    #3 HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // Zero-wait clean pass with timing check
    push_pass(1); pulse_start();
    chk("busy_after_start", {31'b0, busy}, 32'h1);
    wait_done(0);

    // Three wait cycles on the write to 0x10
    clear_cfg(); stall_addr = START + 32'h10; stall_len = 3;
    push_pass(0); pulse_start(); wait_done(0);
    chk("mem_0x10", mem[4], SEED ^ (START + 32'h10));

    // Corrupted word at 0x24
    clear_cfg(); corrupt[9] = 1;
    push_pass(1); pulse_start(); wait_done(0);

    // Error response on every read
    clear_cfg(); resp_err = 1;
    push_pass(1); pulse_start(); wait_done(0);

    // Asynchronous reset during the read half
    clear_cfg();
    push_pass(0); pulse_start();
    k = 0;
    while (!(HRESETn && !HWRITE && HTRANS[1]) && k < 200) begin @(negedge HCLK); k++; end
    if (k >= 200) chk("reach_read_phase_htrans", {30'b0, HTRANS}, 32'h2);
    repeat ($urandom_range(0, 5)) @(negedge HCLK);
    #3 HRESETn = 1'b0;
    exp_q.delete(); res_q.delete();
    #1 check_reset_values("midrd");
    repeat (2) @(negedge HCLK);
    #3 HRESETn = 1'b1;
    repeat (8) @(negedge HCLK);
    push_pass(1); pulse_start(); wait_done(0);

    // Randomized passes: random waits, corruption, errors and stray starts
    for (int p = 0; p < 6; p++) begin
      clear_cfg();
      rand_wait = 1;
      resp_err = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < N; i++) corrupt[i] = ($urandom_range(0, 7) == 0);
      push_pass(0); pulse_start(); wait_done(1);
    end

    repeat (5) @(negedge HCLK);
    chk("leftover_transfers", exp_q.size(), 32'h0);
    chk("leftover_results", res_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
